counter_0_7: RTL and testbench

COUNTER_0_7 -- requirements
Module: counter_0_7

---
 rtl/counter_0_7_pkg.sv | 15 +
 rtl/counter_0_7_up_down_next.sv | 46 ++++
 rtl/counter_0_7.sv | 55 +++++
 tb/tb_counter_0_7.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/counter_0_7_pkg.sv
// ---------------------------------------------------------------------------
// counter_0_7_pkg
//   Shared constants for the up/down wrap-around counter.
//   DEFAULT_WIDTH      : default counter width (range 0..2**WIDTH-1)
//   MODE_UP/MODE_DOWN  : encoding of the mode input
//   DEFAULT_RESET_VAL  : value loaded into q on reset
// ---------------------------------------------------------------------------
package counter_0_7_pkg;

  localparam int   DEFAULT_WIDTH     = 3;
  localparam logic MODE_UP           = 1'b1;
  localparam logic MODE_DOWN         = 1'b0;
  localparam int   DEFAULT_RESET_VAL = 0;

endpackage : counter_0_7_pkg

// File: rtl/counter_0_7_up_down_next.sv
// ---------------------------------------------------------------------------
// up_down_next
//   Purely combinational next-state logic for the counter.
//   Ports:
//     q         in   WIDTH  current count
//     mode      in   1      1 = count up, 0 = count down
//     q_next    out  WIDTH  count to load at the next edge
//     wrap_next out  1      high when this step crosses the 0 / max boundary
// ---------------------------------------------------------------------------
module up_down_next
  import counter_0_7_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_W  = {WIDTH{1'b1}};

  // Next count and wrap flag; wrap-around comes from WIDTH-bit truncation.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    case (mode)
      MODE_UP: begin
        q_next    = q + ONE_W;
        wrap_next = (q == MAX_W);
      end
      MODE_DOWN: begin
        q_next    = q - ONE_W;
        wrap_next = (q == ZERO_W);
      end
      default: begin
        // mode X/Z is illegal; hold rather than propagate garbage
        q_next    = q;
        wrap_next = 1'b0;
      end
    endcase
  end

endmodule : up_down_next

// File: rtl/counter_0_7.sv
// ---------------------------------------------------------------------------
// counter_0_7
//   Free-running up/down counter that wraps modulo 2**WIDTH, with a
//   registered one-cycle wrap pulse.
//   Ports:
//     clk   in   1      rising-edge clock for all state
//     rst   in   1      synchronous active-high reset (priority over counting)
//     mode  in   1      1 = count up, 0 = count down (sampled at the edge)
//     q     out  WIDTH  current count, straight from a register
//     wrap  out  1      high for the cycle after q wrapped (max->0 or 0->max)
// ---------------------------------------------------------------------------
module counter_0_7
  import counter_0_7_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;

  up_down_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q         (q_r),
    .mode      (mode),
    .q_next    (q_next_s),
    .wrap_next (wrap_next_s)
  );

  // Count and wrap registers; reset wins over counting on every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= RESET_Q;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;

endmodule : counter_0_7

// File: tb/tb_counter_0_7.sv
// ---------------------------------------------------------------------------
// tb_counter_0_7
//   Directed stimulus with hand-computed expectations pushed into a queue;
//   a separate monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_counter_0_7;

  typedef struct {
    logic [2:0] q;
    logic       wrap;
    int         id;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [2:0] q;
  logic       wrap;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   step_id;

  counter_0_7 #(
    .WIDTH     (3),
    .RESET_VAL (0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .q    (q),
    .wrap (wrap)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one edge worth of inputs and queue what the DUT must show after it.
  task automatic step(input logic r, input logic m, input logic [2:0] eq, input logic ew);
    exp_t e;
    @(negedge clk);
    rst  = r;
    mode = m;
    e.q    = eq;
    e.wrap = ew;
    e.id   = step_id;
    exp_q.push_back(e);
    step_id++;
  endtask

  // Monitor: one output per rising edge, sampled 1 ns after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (q !== e.q) begin
          errors++;
          $display("FAIL q step %0d: got %0d expected %0d", e.id, q, e.q);
        end
        checks++;
        if (wrap !== e.wrap) begin
          errors++;
          $display("FAIL wrap step %0d: got %0b expected %0b", e.id, wrap, e.wrap);
        end
      end
    end
  end

  initial begin
    exp_t e;
    checks  = 0;
    errors  = 0;
    step_id = 0;
    rst     = 1'b1;
    mode    = 1'b0;

    // Reset with mode=0
    step(1'b0 | 1'b1, 1'b0, 3'd0, 1'b0);

    // Up 9 edges: 1..7, 0 (wrap), 1
    for (int v = 1; v <= 7; v++) step(1'b0, 1'b1, 3'(v), 1'b0);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b0);

    // Reset with mode=1, then down 3 edges: 7 (wrap), 6, 5
    step(1'b1, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd7, 1'b1);
    step(1'b0, 1'b0, 3'd6, 1'b0);
    step(1'b0, 1'b0, 3'd5, 1'b0);

    // Direction change at q=5: 4, 3 with no skipped value
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int v = 1; v <= 5; v++) step(1'b0, 1'b1, 3'(v), 1'b0);
    step(1'b0, 1'b0, 3'd4, 1'b0);
    step(1'b0, 1'b0, 3'd3, 1'b0);

    // Reset mid-count at q=6, release counting up
    step(1'b0, 1'b1, 3'd4, 1'b0);
    step(1'b0, 1'b1, 3'd5, 1'b0);
    step(1'b0, 1'b1, 3'd6, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 1'b0);

    // Reset on what would be a wrap edge (q=7, up): wrap must stay 0
    for (int v = 2; v <= 7; v++) step(1'b0, 1'b1, 3'(v), 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b0);
    // Down-wrap then immediate up-wrap across the mode change
    step(1'b0, 1'b0, 3'd7, 1'b1);
    step(1'b0, 1'b1, 3'd0, 1'b1);

    // Short rst glitch between edges at q=4 must be ignored
    for (int v = 1; v <= 4; v++) step(1'b0, 1'b1, 3'(v), 1'b0);
    @(negedge clk);
    mode = 1'b1;
    rst  = 1'b0;
    e.q    = 3'd5;
    e.wrap = 1'b0;
    e.id   = step_id;
    exp_q.push_back(e);
    step_id++;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    step(1'b0, 1'b1, 3'd6, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_0_7
